// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI shift-register data path.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned SPI_DATA_W = 8;

  // Position within the frame of the k-th transferred bit.
  function automatic int unsigned bit_idx(input logic lsbfe, input int unsigned k,
                                          input int unsigned w);
    return lsbfe ? k : (w - 1 - k);
  endfunction

endpackage

// File: rtl/spi_edge_select.sv
// Picks the active send/sample strobe pair from the latched cpol^cpha.
module spi_edge_select
  import spi_pkg::*;
(
  input  logic sel,
  input  logic mosi_send_sclk_i,
  input  logic mosi_send_sclk0_i,
  input  logic miso_receive_sclk_i,
  input  logic miso_receive_sclk0_i,
  output logic send_stb,
  output logic recv_stb
);

  always_comb begin
    send_stb = sel ? mosi_send_sclk0_i    : mosi_send_sclk_i;
    recv_stb = sel ? miso_receive_sclk0_i : miso_receive_sclk_i;
  end

endmodule

// File: rtl/spi_shift_register.sv
// SPI master shift register: serialises TX onto MOSI, deserialises MISO into RX.
// Optional self-test loopback (RX samples mosi_o) under SPI_SHIFT_LOOPBACK_EN.
module spi_shift_register
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W = SPI_DATA_W
) (
  input  logic              PCLK,
  input  logic              PRESET_n,
  input  logic              ss_i,
  input  logic              send_data_i,
  input  logic              lsbfe_i,
  input  logic              cpol_i,
  input  logic              cpha_i,
  input  logic              mosi_send_sclk_i,
  input  logic              mosi_send_sclk0_i,
  input  logic              miso_receive_sclk_i,
  input  logic              miso_receive_sclk0_i,
  input  logic [DATA_W-1:0] data_mosi_i,
  input  logic              miso_i,
  input  logic              loop_i,
  output logic              mosi_o,
  output logic [DATA_W-1:0] data_miso_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int unsigned CNT_W = $clog2(DATA_W) + 1;
  localparam int unsigned IDX_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] tx_reg, rx_reg, rx_nxt;
  logic [CNT_W-1:0]  tx_cnt, rx_cnt;
  logic              lsbfe_q, sel_q;
  logic              send_stb, recv_stb, start, rx_bit;
  logic [IDX_W-1:0]  load_idx, tx_idx, rx_idx;

  spi_edge_select u_edge_select (
    .sel                  (sel_q),
    .mosi_send_sclk_i     (mosi_send_sclk_i),
    .mosi_send_sclk0_i    (mosi_send_sclk0_i),
    .miso_receive_sclk_i  (miso_receive_sclk_i),
    .miso_receive_sclk0_i (miso_receive_sclk0_i),
    .send_stb             (send_stb),
    .recv_stb             (recv_stb)
  );

`ifdef SPI_SHIFT_LOOPBACK_EN
  assign rx_bit = loop_i ? mosi_o : miso_i;
`else
  logic unused_loop;
  assign unused_loop = loop_i;
  assign rx_bit      = miso_i;
`endif

  always_comb begin
    start    = send_data_i & ~ss_i;
    load_idx = IDX_W'(bit_idx(lsbfe_i, 0, DATA_W));
    tx_idx   = IDX_W'(bit_idx(lsbfe_q, 32'(tx_cnt), DATA_W));
    rx_idx   = IDX_W'(bit_idx(lsbfe_q, 32'(rx_cnt), DATA_W));
    rx_nxt         = rx_reg;
    rx_nxt[rx_idx] = rx_bit;
  end

  always_ff @(posedge PCLK) begin
    if (!PRESET_n) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = SHIFT;
      SHIFT: begin
        busy_o = 1'b1;
        if (ss_i)                              state_nxt = IDLE;
        else if (recv_stb && rx_cnt == CNT_LAST) state_nxt = DONE;
      end
      DONE: begin
        done_o    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESET_n) begin
      mosi_o      <= 1'b0;
      data_miso_o <= '0;
      tx_reg      <= '0;
      rx_reg      <= '0;
      tx_cnt      <= '0;
      rx_cnt      <= '0;
      lsbfe_q     <= 1'b0;
      sel_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          tx_reg  <= data_mosi_i;
          rx_reg  <= '0;
          lsbfe_q <= lsbfe_i;
          sel_q   <= cpol_i ^ cpha_i;
          rx_cnt  <= '0;
          if (cpha_i) begin
            tx_cnt <= '0;
          end else begin
            mosi_o <= data_mosi_i[load_idx];
            tx_cnt <= CNT_ONE;
          end
        end
        SHIFT: begin
          if (ss_i) begin
            mosi_o <= 1'b0;
            tx_cnt <= '0;
            rx_cnt <= '0;
          end else begin
            if (send_stb && tx_cnt < CNT_FULL) begin
              mosi_o <= tx_reg[tx_idx];
              tx_cnt <= tx_cnt + CNT_ONE;
            end
            // Publish the word with its final bit merged so it is valid alongside done_o.
            if (recv_stb) begin
              rx_reg <= rx_nxt;
              rx_cnt <= rx_cnt + CNT_ONE;
              if (rx_cnt == CNT_LAST) data_miso_o <= rx_nxt;
            end
          end
        end
        DONE: begin
          tx_cnt <= '0;
          rx_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_shift_register.sv
// Directed self-checking bench for spi_shift_register (loopback case under SPI_SHIFT_LOOPBACK_EN).
module tb_spi_shift_register;

  localparam int unsigned W = 8;

  logic         PCLK = 1'b0;
  logic         PRESET_n;
  logic         ss_i, send_data_i, lsbfe_i, cpol_i, cpha_i;
  logic         mosi_send_sclk_i, mosi_send_sclk0_i;
  logic         miso_receive_sclk_i, miso_receive_sclk0_i;
  logic [W-1:0] data_mosi_i;
  logic         miso_i, loop_i;
  logic         mosi_o, busy_o, done_o;
  logic [W-1:0] data_miso_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 PCLK = ~PCLK;

  spi_shift_register #(.DATA_W(W)) dut (
    .PCLK                 (PCLK),
    .PRESET_n             (PRESET_n),
    .ss_i                 (ss_i),
    .send_data_i          (send_data_i),
    .lsbfe_i              (lsbfe_i),
    .cpol_i               (cpol_i),
    .cpha_i               (cpha_i),
    .mosi_send_sclk_i     (mosi_send_sclk_i),
    .mosi_send_sclk0_i    (mosi_send_sclk0_i),
    .miso_receive_sclk_i  (miso_receive_sclk_i),
    .miso_receive_sclk0_i (miso_receive_sclk0_i),
    .data_mosi_i          (data_mosi_i),
    .miso_i               (miso_i),
    .loop_i               (loop_i),
    .mosi_o               (mosi_o),
    .data_miso_o          (data_miso_o),
    .busy_o               (busy_o),
    .done_o               (done_o)
  );

  task automatic clk1;
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  // Active pair gets snd/rcv; the other pair gets decoy strobes that must be ignored.
  task automatic set_strobes(input logic sel, input logic snd, input logic rcv,
                             input logic x_snd, input logic x_rcv);
    if (!sel) begin
      mosi_send_sclk_i = snd;   miso_receive_sclk_i = rcv;
      mosi_send_sclk0_i = x_snd; miso_receive_sclk0_i = x_rcv;
    end else begin
      mosi_send_sclk0_i = snd;   miso_receive_sclk0_i = rcv;
      mosi_send_sclk_i = x_snd;  miso_receive_sclk_i = x_rcv;
    end
  endtask

  task automatic frame(input logic [W-1:0] tx, input logic [W-1:0] rx, input logic lsbfe,
                       input logic cpol, input logic cpha, input int unsigned nbits,
                       input logic glitch, input logic loop, input logic pre_mosi);
    logic         sel;
    logic [W-1:0] exp_rx;
    int unsigned  b, b2;
    sel    = cpol ^ cpha;
    exp_rx = loop ? tx : rx;
    data_mosi_i = tx; lsbfe_i = lsbfe; cpol_i = cpol; cpha_i = cpha;
    loop_i = loop; ss_i = 1'b0; send_data_i = 1'b1;
    clk1;
    send_data_i = 1'b0;
    chk1("busy_load", busy_o, 1'b1);
    b = lsbfe ? 0 : W - 1;
    chk1("mosi_load", mosi_o, cpha ? pre_mosi : tx[b]);
    for (int unsigned k = 0; k < nbits; k++) begin
      b = lsbfe ? k : W - 1 - k;
      if (cpha) begin
        miso_i = ~rx[b];
        set_strobes(sel, 1'b1, 1'b0, 1'b0, 1'b1);
        clk1;
        set_strobes(sel, 1'b0, 1'b0, 1'b0, 1'b0);
        chk1("mosi_send", mosi_o, tx[b]);
      end
      miso_i = loop ? ~tx[b] : rx[b];
      set_strobes(sel, 1'b0, 1'b1, 1'b1, 1'b0);
      if (glitch && k == 2) begin
        send_data_i = 1'b1; data_mosi_i = ~tx; lsbfe_i = ~lsbfe;
        cpha_i = ~cpha; cpol_i = ~cpol;
      end
      clk1;
      set_strobes(sel, 1'b0, 1'b0, 1'b0, 1'b0);
      send_data_i = 1'b0;
      chk1("mosi_after_rx", mosi_o, tx[b]);
      if (k == W - 1) begin
        chk1("done_pulse", done_o, 1'b1);
        chk1("busy_at_done", busy_o, 1'b0);
        chk8("rx_word", data_miso_o, exp_rx);
      end else begin
        chk1("busy_mid", busy_o, 1'b1);
        chk1("done_mid", done_o, 1'b0);
      end
      if (!cpha && k < W - 1) begin
        b2 = lsbfe ? k + 1 : W - 2 - k;
        miso_i = ~rx[b2];
        set_strobes(sel, 1'b1, 1'b0, 1'b0, 1'b1);
        clk1;
        set_strobes(sel, 1'b0, 1'b0, 1'b0, 1'b0);
        chk1("mosi_send", mosi_o, tx[b2]);
      end
    end
    if (nbits == W) begin
      b = lsbfe ? W - 1 : 0;
      set_strobes(sel, 1'b1, 1'b1, 1'b0, 1'b0);
      clk1;
      set_strobes(sel, 1'b0, 1'b0, 1'b0, 1'b0);
      chk1("done_one_cycle", done_o, 1'b0);
      chk1("busy_after", busy_o, 1'b0);
      chk1("mosi_hold_last", mosi_o, tx[b]);
      chk8("rx_word_hold", data_miso_o, exp_rx);
    end
  endtask

  initial begin
    PRESET_n = 1'b0; ss_i = 1'b1; send_data_i = 1'b0; lsbfe_i = 1'b0;
    cpol_i = 1'b0; cpha_i = 1'b0; data_mosi_i = '0; miso_i = 1'b0; loop_i = 1'b0;
    mosi_send_sclk_i = 1'b0; mosi_send_sclk0_i = 1'b0;
    miso_receive_sclk_i = 1'b0; miso_receive_sclk0_i = 1'b0;
    clk1;
    clk1;
    chk1("rst_mosi", mosi_o, 1'b0);
    chk1("rst_busy", busy_o, 1'b0);
    chk1("rst_done", done_o, 1'b0);
    chk8("rst_data", data_miso_o, 8'h00);
    PRESET_n = 1'b1;
    clk1;

    // Mode 0, MSB first.
    frame(8'hA5, 8'h3C, 1'b0, 1'b0, 1'b0, W, 1'b0, 1'b0, 1'b0);

    // Abort after four receive strobes.
    frame(8'hFF, 8'h0F, 1'b0, 1'b0, 1'b0, 4, 1'b0, 1'b0, 1'b0);
    ss_i = 1'b1;
    clk1;
    chk1("abort_busy", busy_o, 1'b0);
    chk1("abort_done", done_o, 1'b0);
    chk1("abort_mosi", mosi_o, 1'b0);
    chk8("abort_data", data_miso_o, 8'h3C);
    ss_i = 1'b0;
    clk1;
    chk1("abort_no_done", done_o, 1'b0);

    // Mode 3, LSB first; mosi stays 0 from the abort at load.
    frame(8'hA5, 8'hC3, 1'b1, 1'b1, 1'b1, W, 1'b0, 1'b0, 1'b0);

    // Strobes in IDLE are ignored.
    mosi_send_sclk_i = 1'b1; mosi_send_sclk0_i = 1'b1;
    miso_receive_sclk_i = 1'b1; miso_receive_sclk0_i = 1'b1; miso_i = 1'b0;
    repeat (3) clk1;
    set_strobes(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk1("idle_busy", busy_o, 1'b0);
    chk1("idle_mosi", mosi_o, 1'b1);
    chk8("idle_data", data_miso_o, 8'hC3);

    // Control inputs disturbed mid-frame must not matter.
    frame(8'h81, 8'h5A, 1'b0, 1'b0, 1'b0, W, 1'b1, 1'b0, 1'b0);

    // Mode 1 round trips.
    frame(8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, W, 1'b0, 1'b0, 1'b1);
    frame(8'h00, 8'hFF, 1'b1, 1'b0, 1'b1, W, 1'b0, 1'b0, 1'b1);

    // Reset mid-frame.
    frame(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0);
    PRESET_n = 1'b0;
    clk1;
    chk1("midrst_mosi", mosi_o, 1'b0);
    chk1("midrst_busy", busy_o, 1'b0);
    chk1("midrst_done", done_o, 1'b0);
    chk8("midrst_data", data_miso_o, 8'h00);
    PRESET_n = 1'b1;
    clk1;

    // Mode 2, LSB first, after reset.
    frame(8'h3C, 8'h96, 1'b1, 1'b1, 1'b0, W, 1'b0, 1'b0, 1'b0);

`ifdef SPI_SHIFT_LOOPBACK_EN
    frame(8'h5A, 8'h00, 1'b0, 1'b0, 1'b0, W, 1'b0, 1'b1, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_shift_register.md
Name: spi_shift_register

Overview:
- Data path stage directly downstream of spi_baud_generator in the SPI master.
- Consumes the baud generator's one-PCLK edge strobes (mosi_send_sclk*, miso_receive_sclk*) to serialise a parallel TX byte onto MOSI and deserialise MISO into an RX byte.
- Sits between the APB register slice (TX/RX data regs, control bits) and the SPI pins.
- Supports all four CPOL/CPHA modes and MSB- or LSB-first ordering.

Parameters:
- DATA_W, 8, frame width in bits (>=2).

Ports:
- PCLK  in  1  system clock; all logic rising-edge.
- PRESET_n  in  1  reset, synchronous, active-low.
- ss_i  in  1  slave select from baud/control logic; low = frame active.
- send_data_i  in  1  one-cycle request to start a frame.
- lsbfe_i  in  1  1 = LSB first, 0 = MSB first.
- cpol_i  in  1  clock polarity.
- cpha_i  in  1  clock phase.
- mosi_send_sclk_i  in  1  send strobe, used when cpol^cpha = 0.
- mosi_send_sclk0_i  in  1  send strobe, used when cpol^cpha = 1.
- miso_receive_sclk_i  in  1  sample strobe, used when cpol^cpha = 0.
- miso_receive_sclk0_i  in  1  sample strobe, used when cpol^cpha = 1.
- data_mosi_i  in  DATA_W  parallel TX data.
- miso_i  in  1  serial input pin.
- loop_i  in  1  loopback select; only honoured under the optional feature.
- mosi_o  out  1  serial output pin.
- data_miso_o  out  DATA_W  last completed RX word.
- busy_o  out  1  frame in progress.
- done_o  out  1  one-cycle pulse at frame completion.

Behaviour:
- Reset:
  - PRESET_n is sampled only on the PCLK rising edge.
  - While low: mosi_o=0, data_miso_o=0, busy_o=0, done_o=0, tx/rx shift regs=0, tx_cnt=rx_cnt=0, state IDLE.
- States: IDLE, SHIFT, DONE.
- IDLE -> SHIFT:
  - Trigger: send_data_i=1 and ss_i=0.
  - Latch data_mosi_i, lsbfe_i, cpha_i and the strobe select (cpol^cpha).
  - busy_o=1 from the next cycle.
  - Control inputs are ignored mid-frame.
- Bit index: bit(k) = lsbfe ? k : DATA_W-1-k.
- TX:
  - cpha=0: on the load cycle, mosi_o <= tx[bit(0)] and tx_cnt=1.
  - cpha=1: mosi_o is unchanged at load and tx_cnt=0.
  - In SHIFT, each selected send strobe with tx_cnt<DATA_W drives mosi_o <= tx[bit(tx_cnt)] and increments tx_cnt.
  - Surplus send strobes are ignored.
- RX:
  - In SHIFT, each selected receive strobe writes rx[bit(rx_cnt)] <= miso_i and increments rx_cnt.
  - When rx_cnt reaches DATA_W-1 and a receive strobe occurs, the next state is DONE.
- Same-cycle send and receive strobes: both take effect.
- DONE (one cycle):
  - data_miso_o <= completed rx word (including the final bit).
  - done_o=1, busy_o=0, counters cleared.
  - Next state IDLE. mosi_o holds its last bit.
- Latency: done_o asserts 1 PCLK after the cycle carrying the DATA_W-th receive strobe.
- Abort:
  - Trigger: ss_i=1 during SHIFT.
  - Next cycle: state IDLE, busy_o=0, no done_o, mosi_o=0, data_miso_o unchanged, counters cleared.
- send_data_i while busy or in DONE is dropped (no queueing).
- Strobes in IDLE are ignored.
- Counter width: $clog2(DATA_W)+1; counters never wrap.
- Reset asserted mid-frame overrides everything on the next edge.

Optional Feature:
- Macro: SPI_SHIFT_LOOPBACK_EN.
- Defined: when loop_i=1, the RX path samples mosi_o instead of miso_i (self-test; pins unaffected).
- Undefined: loop_i is ignored and RX always samples miso_i.

Decomposition:
- spi_pkg:
  - state enum (IDLE/SHIFT/DONE)
  - default DATA_W constant
  - bit-index function
- Sub-module spi_edge_select:
  - purely combinational; muxes the sclk/sclk0 strobe pairs using the latched cpol^cpha.
  - Also used by the control block.

Test Plan:
- Mode 0 (cpol=0, cpha=0), MSB first, data_mosi_i=8'hA5, miso_i pattern 8'h3C, 8 strobe pairs -> mosi_o sequence 1,0,1,0,0,1,0,1 (first bit at load); data_miso_o=8'h3C; done_o one pulse; busy_o high 8 strobes.
- Mode 3 (cpol=1, cpha=1), LSB first, 8'hA5 -> mosi_o changes only on mosi_send_sclk_i: 1,0,1,0,0,1,0,1; *0 strobes have no effect; RX 8'hC3 received LSB first -> data_miso_o=8'hC3.
- Mode 1 (cpol=0, cpha=1) -> only *0 strobes act; full 8'hFF/8'h00 round trip correct.
- ss_i raised after 4 receive strobes -> IDLE next cycle, no done_o, data_miso_o keeps prior 8'h3C, mosi_o=0; new send_data_i then completes normally.
- send_data_i pulsed mid-frame, and strobes in IDLE -> no effect on counters or output.
- Reset asserted mid-frame -> all outputs 0 on next PCLK edge; with SPI_SHIFT_LOOPBACK_EN and loop_i=1, TX 8'h5A -> data_miso_o=8'h5A.
